demux4_latch: RTL

- Registered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 select mux (i0..i3, s1/s2 -> d).
- Routes input `d` into one of four held output registers `o0`..`o3`.
- Select comes either from the external `s1`/`s2` pins or from an internal scan counter that fills `o0`..`o3` in order and flags each completed frame.
- Used to rebuild a 4-word frame from a serialised mux stream.

---
 rtl/demux4_latch_pkg.sv | 11 +
 rtl/demux4_latch_scan_ctr2.sv | 29 ++
 rtl/demux4_latch.sv | 97 +++++++++
 3 files changed

// File: rtl/demux4_latch_pkg.sv
// Shared select encoding for the 4:1 mux / 1:4 demux pair, plus the default data width.
package demux4_latch_pkg;

  localparam logic [1:0] SEL_O0 = 2'b00;
  localparam logic [1:0] SEL_O1 = 2'b01;
  localparam logic [1:0] SEL_O2 = 2'b10;
  localparam logic [1:0] SEL_O3 = 2'b11;

  localparam int DEMUX_WIDTH_DEF = 1;

endpackage

// File: rtl/demux4_latch_scan_ctr2.sv
// Modulo-4 scan counter with increment enable and synchronous clear (clear wins).
// Count is registered; o_tc flags the last slot (SEL_O3) combinationally from the count.
module scan_ctr2
  import demux4_latch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [1:0] o_cnt,
  output logic       o_tc
);

  logic [1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= SEL_O0;
    end else if (i_clr) begin
      r_cnt <= SEL_O0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == SEL_O3);

endmodule

// File: rtl/demux4_latch.sv
// Registered 1:4 demux rebuilding 4-word frames from a serial stream; outputs update one
// cycle after the accepting edge, one write per cycle with no stalls or backpressure.
module demux4_latch
  import demux4_latch_pkg::*;
#(
  parameter int WIDTH       = DEMUX_WIDTH_DEF,
  parameter int CLEAR_UNSEL = 0
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s2,
  input  logic             wr_en,
  input  logic             scan,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       vld,
  output logic [1:0]       sel_q,
  output logic             frame_done
);

  logic [WIDTH-1:0] r_o [4];
  logic [3:0]       r_vld;
  logic [1:0]       r_sel_q;
  logic             r_frame_done;

  logic [1:0] w_cnt;
  logic       w_tc;
  logic [1:0] w_sel;
  logic [3:0] w_onehot;
  logic       w_frame_start;

  // Holding the counter in clear while scan is low makes every scan entry start at o0.
  scan_ctr2 u_scan_ctr2 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (wr_en & scan),
    .i_clr (~scan),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  assign w_sel         = scan ? w_cnt : {s1, s2};
  assign w_frame_start = wr_en & scan & (w_cnt == SEL_O0);

  always_comb begin
    w_onehot = 4'b0000;
    case (w_sel)
      SEL_O0: w_onehot = 4'b0001;
      SEL_O1: w_onehot = 4'b0010;
      SEL_O2: w_onehot = 4'b0100;
      SEL_O3: w_onehot = 4'b1000;
      default: w_onehot = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        r_o[n] <= '0;
      end
      r_vld        <= 4'b0000;
      r_sel_q      <= SEL_O0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= wr_en & scan & w_tc;
      if (wr_en) begin
        r_sel_q <= w_sel;
        for (int n = 0; n < 4; n++) begin
          if (w_onehot[n]) begin
            r_o[n]   <= d;
            r_vld[n] <= 1'b1;
          end else if ((CLEAR_UNSEL != 0) || w_frame_start) begin
            // A new scan frame only restarts the flags; data clears only in pure-demux mode.
            if (CLEAR_UNSEL != 0) begin
              r_o[n] <= '0;
            end
            r_vld[n] <= 1'b0;
          end
        end
      end
    end
  end

  assign o0         = r_o[0];
  assign o1         = r_o[1];
  assign o2         = r_o[2];
  assign o3         = r_o[3];
  assign vld        = r_vld;
  assign sel_q      = r_sel_q;
  assign frame_done = r_frame_done;

endmodule
